fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the register-file/ALU stage. Holds the program counter, issues one word-aligned request at a time to instruction memory over a req/gnt/rvalid interface, and buffers the returned instruction for decode behind a valid/ready handshake. Branch and jump redirects from the execute side update the PC and kill any in-flight or buffered fetch. Decode slices the buffered word into rs1/rs2/rd/ImmOp for the register-file/ALU stage.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_target.sv | 26 ++
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// State encoding, the canonical NOP word and the default boot address.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        DROP
    } fetch_state_t;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_target.sv
// Redirect target: base+imm or jalr target with bit 0 cleared, then word-aligned.
// Latency: combinational. Backpressure: none.
// Flags targets whose low two bits were not zero.
module fetch_target #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  sel_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    input  logic [DATA_WIDTH-1:0] alu_i,
    output logic [ADDR_WIDTH-1:0] target_o,
    output logic                  misalign_o
);

    logic [ADDR_WIDTH-1:0] imm_t;
    logic [ADDR_WIDTH-1:0] alu_t;
    logic [ADDR_WIDTH-1:0] raw;

    assign imm_t      = ADDR_WIDTH'(imm_i);
    assign alu_t      = ADDR_WIDTH'(alu_i);
    assign raw        = sel_i ? {alu_t[ADDR_WIDTH-1:1], 1'b0} : (base_i + imm_t);
    assign target_o   = {raw[ADDR_WIDTH-1:2], 2'b00};
    assign misalign_o = |raw[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word request, single-entry buffer toward decode.
// Latency: gnt at N, rvalid at N+k -> instr_valid from N+k+1. Backpressure: no new request while buffer full.
// Redirects kill in-flight/buffered fetches; a granted-but-dead request is drained in DROP.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  redirect_valid,
    input  logic                  redirect_sel,
    input  logic [ADDR_WIDTH-1:0] redirect_base,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    input  logic [DATA_WIDTH-1:0] ALUout,
    output logic                  misalign_err
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  misalign_q, misalign_d;

    logic [ADDR_WIDTH-1:0] redir_target;
    logic                  redir_misalign;

    fetch_target #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_target (
        .sel_i      (redirect_sel),
        .base_i     (redirect_base),
        .imm_i      (ImmOp),
        .alu_i      (ALUout),
        .target_o   (redir_target),
        .misalign_o (redir_misalign)
    );

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;

        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything; any request the memory already owns must be drained.
        if (redirect_valid && state_q != IDLE) begin
            fetch_pc_d    = redir_target;
            instr_valid_d = 1'b0;
            if (redir_misalign) misalign_d = 1'b1;
            if (state_q == WAIT || state_q == DROP || (state_q == FETCH && imem_gnt))
                state_d = DROP;
            else
                state_d = FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign imem_req     = (state_q == FETCH);
    assign imem_addr    = fetch_pc_q;
    assign instr_valid  = instr_valid_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model (outstanding request,
// buffer slot) checked every cycle, plus hand-computed literal expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic        redirect_sel;
    logic [31:0] redirect_base;
    logic [31:0] ImmOp;
    logic [31:0] ALUout;
    logic        misalign_err;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .redirect_base  (redirect_base),
        .ImmOp          (ImmOp),
        .ALUout         (ALUout),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    bit done   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: the unit owns at most one memory transaction and one buffer slot.
    // It asks for a word whenever it is running, has nothing outstanding and the slot is free.
    bit          m_started = 1'b0;
    bit          m_busy    = 1'b0;
    bit          m_live    = 1'b0;
    bit          m_bv      = 1'b0;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_rpc     = 32'h0;
    logic [31:0] m_buf     = 32'h0;
    logic [31:0] m_bpc     = 32'h0;
    bit          m_err     = 1'b0;

    function automatic bit m_req();
        return m_started && !m_busy && !m_bv;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started = 0; m_busy = 0; m_live = 0; m_bv = 0;
            m_pc = 32'h0; m_rpc = 32'h0; m_buf = 32'h0; m_bpc = 32'h0; m_err = 0;
        end else begin
            bit granted;
            logic [31:0] t;
            granted = m_req() && imem_gnt;
            if (!m_started) begin
                m_started = 1;
            end else if (redirect_valid) begin
                t = redirect_sel ? (ALUout & 32'hFFFF_FFFE) : (redirect_base + ImmOp);
                if (t[1:0] != 2'b00) m_err = 1;
                m_pc   = t & 32'hFFFF_FFFC;
                m_bv   = 0;
                m_busy = m_busy || granted;
                m_live = 0;
            end else if (granted) begin
                m_busy = 1; m_live = 1; m_rpc = m_pc; m_pc = m_pc + 32'd4;
            end else if (m_busy && imem_rvalid) begin
                m_busy = 0;
                if (m_live) begin
                    m_bv = 1; m_buf = imem_rdata; m_bpc = m_rpc;
                end
            end else if (m_bv && instr_ready) begin
                m_bv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            check("model_req",   {31'b0, imem_req},     {31'b0, m_req()});
            check("model_addr",  imem_addr,             m_pc);
            check("model_valid", {31'b0, instr_valid},  {31'b0, m_bv});
            check("model_err",   {31'b0, misalign_err}, {31'b0, m_err});
            if (m_bv) begin
                check("model_instr",    instr,    m_buf);
                check("model_instr_pc", instr_pc, m_bpc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = 0; instr_ready = 0;
        redirect_valid = 0; redirect_sel = 0; redirect_base = 0; ImmOp = 0; ALUout = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'b0, imem_req},     32'd0);
        check("rst_addr",  imem_addr,             32'h0);
        check("rst_valid", {31'b0, instr_valid},  32'd0);
        check("rst_instr", instr,                 32'h0);
        check("rst_err",   {31'b0, misalign_err}, 32'd0);
        rst_n = 1'b1;
        #1 check("idle_req", {31'b0, imem_req}, 32'd0);

        // Basic fetch, zero-wait memory
        tick();
        check("first_req",  {31'b0, imem_req}, 32'd1);
        check("first_addr", imem_addr,         32'h0);
        imem_gnt = 1;
        tick();
        imem_gnt = 0;
        check("wait_noreq", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'h0050_0093;
        tick();
        imem_rvalid = 0;
        check("hold_valid", {31'b0, instr_valid}, 32'd1);
        check("hold_instr", instr,                32'h0050_0093);
        check("hold_pc",    instr_pc,             32'h0);
        instr_ready = 1;
        tick();
        instr_ready = 0;
        check("next_addr",  imem_addr,            32'h4);
        check("next_valid", {31'b0, instr_valid}, 32'd0);

        // Grant withheld: request held stable
        repeat (5) begin
            tick();
            check("stall_req",  {31'b0, imem_req}, 32'd1);
            check("stall_addr", imem_addr,         32'h4);
        end
        imem_gnt = 1;
        tick();
        imem_gnt = 0;
        repeat (2) tick();
        imem_rvalid = 1; imem_rdata = 32'h00A0_0113;
        tick();
        imem_rvalid = 0;

        // Decode stalls in HOLD
        repeat (4) begin
            tick();
            check("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_hold_instr", instr,                32'h00A0_0113);
            check("stall_hold_pc",    instr_pc,             32'h4);
            check("stall_hold_noreq", {31'b0, imem_req},    32'd0);
        end
        instr_ready = 1;
        tick();
        instr_ready = 0;

        // Redirect while waiting: late response dropped
        imem_gnt = 1;
        tick();
        imem_gnt = 0;
        redirect_valid = 1; redirect_sel = 0; redirect_base = 32'h10; ImmOp = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 0;
        check("drop_noreq", {31'b0, imem_req}, 32'd0);
        check("drop_addr",  imem_addr,         32'h8);
        tick();
        imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 0;
        check("drop_valid", {31'b0, instr_valid}, 32'd0);
        check("drop_req",   {31'b0, imem_req},    32'd1);
        check("drop_next",  imem_addr,            32'h8);

        // jalr-style misaligned redirect while requesting
        redirect_valid = 1; redirect_sel = 1; ALUout = 32'h103;
        tick();
        redirect_valid = 0;
        check("jalr_addr", imem_addr,             32'h100);
        check("jalr_err",  {31'b0, misalign_err}, 32'd1);
        imem_gnt = 1;
        tick();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 0;
        check("jalr_pc",     instr_pc,             32'h100);
        check("err_sticky",  {31'b0, misalign_err}, 32'd1);
        instr_ready = 1;
        tick();
        instr_ready = 0;

        // Redirect in the same cycle as a grant: granted word must be drained
        imem_gnt = 1; redirect_valid = 1; redirect_sel = 0;
        redirect_base = 32'hFFFF_FFF0; ImmOp = 32'hC;
        tick();
        imem_gnt = 0; redirect_valid = 0;
        check("gnt_redir_noreq", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'h1111_1111;
        tick();
        imem_rvalid = 0;
        check("gnt_redir_addr",  imem_addr,            32'hFFFF_FFFC);
        check("gnt_redir_valid", {31'b0, instr_valid}, 32'd0);

        // Address wrap
        imem_gnt = 1;
        tick();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0000_0013;
        tick();
        imem_rvalid = 0;
        check("wrap_pc",   instr_pc,  32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);

        // Redirect in HOLD beats a same-cycle consume
        redirect_valid = 1; redirect_sel = 0; redirect_base = 32'h20; ImmOp = 32'h4; instr_ready = 1;
        tick();
        redirect_valid = 0; instr_ready = 0;
        check("hold_redir_valid", {31'b0, instr_valid}, 32'd0);
        check("hold_redir_addr",  imem_addr,            32'h24);

        // Async reset in WAIT
        imem_gnt = 1;
        tick();
        imem_gnt = 0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_req",   {31'b0, imem_req},     32'd0);
        check("arst_addr",  imem_addr,             32'h0);
        check("arst_err",   {31'b0, misalign_err}, 32'd0);
        check("arst_valid", {31'b0, instr_valid},  32'd0);
        tick();
        rst_n = 1'b1;
        imem_rvalid = 1; imem_rdata = 32'h5555_5555;
        tick();
        tick();
        imem_rvalid = 0;
        check("restart_req",   {31'b0, imem_req},    32'd1);
        check("restart_addr",  imem_addr,            32'h0);
        check("restart_valid", {31'b0, instr_valid}, 32'd0);
        imem_gnt = 1;
        tick();
        imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0030_0193;
        tick();
        imem_rvalid = 0;
        check("restart_instr", instr,    32'h0030_0193);
        check("restart_pc",    instr_pc, 32'h0);
        tick();

        done = 1'b1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
